// File: rtl/uart_rx_param.sv
// uart_rx_param
// UART receiver with per-bit oversampling and 3-sample majority voting.
// Parity enable/type, stop-bit count and prescale are latched per frame at
// start detection. Each received word is presented through a one-deep
// valid/ready output register with per-word error flags. Overrun and break
// are reported as single-cycle pulses.
//
// Ports
//   CLK            system clock, rising edge
//   Reset          asynchronous active-low reset
//   S_Data         serial input, idle high, asynchronous to CLK
//   Parity_EN      1 = parity bit follows the data bits
//   Parity_type    0 = even, 1 = odd
//   Stop_bits      0 = one stop bit, 1 = two stop bits
//   Prescale       CLK cycles per bit (even, 6..2^PRESCALE_WIDTH-2)
//   Data_ready     consumer accepts the held word while Data_valid=1
//   P_Data         received word, LSB first on the line
//   Data_valid     P_Data and the error flags hold a word
//   Parity_error   parity mismatch in the held word
//   stop_error     a stop bit of the held word was sampled 0
//   overrun_error  one-cycle pulse: completed frame dropped (register full)
//   break_detect   one-cycle pulse: break frame recognised
//
// State table
//   state     | meaning
//   ST_IDLE   | line idle, waiting for a falling edge
//   ST_START  | inside start bit, glitch rejection at the vote point
//   ST_DATA   | shifting data bits in, LSB first
//   ST_PARITY | sampling and checking the parity bit
//   ST_STOP   | sampling one or two stop bits, frame completion
//   ST_BREAK  | break frame seen, waiting for the line to return high

module uart_rx_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      S_Data,
  input  logic                      Parity_EN,
  input  logic                      Parity_type,
  input  logic                      Stop_bits,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      Data_ready,
  output logic [DATA_WIDTH-1:0]     P_Data,
  output logic                      Data_valid,
  output logic                      Parity_error,
  output logic                      stop_error,
  output logic                      overrun_error,
  output logic                      break_detect
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] ONE_P   = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]                DW_LAST = 4'(DATA_WIDTH - 1);

  // synchroniser and frame state
  logic [1:0]                sync_q,       sync_d;
  state_t                    state_q,      state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q,        cnt_d;
  logic [PRESCALE_WIDTH-1:0] p_q,          p_d;
  logic [3:0]                bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q,      shift_d;
  logic [1:0]                samp_q,       samp_d;
  logic                      par_en_q,     par_en_d;
  logic                      par_type_q,   par_type_d;
  logic                      stop2_q,      stop2_d;
  logic                      stop_idx_q,   stop_idx_d;
  logic                      zero_q,       zero_d;
  logic                      par_err_q,    par_err_d;
  logic                      stop_err_q,   stop_err_d;

  // output register
  logic [DATA_WIDTH-1:0]     p_data_q,     p_data_d;
  logic                      valid_q,      valid_d;
  logic                      perr_q,       perr_d;
  logic                      serr_q,       serr_d;
  logic                      ovr_q,        ovr_d;
  logic                      brk_q,        brk_d;

  logic                      line;
  logic [PRESCALE_WIDTH-1:0] half;
  logic                      at_s0, at_s1, at_vote, at_end;
  logic                      vote;
  logic                      in_bit;

  assign line    = sync_q[1];
  assign half    = p_q >> 1;
  assign at_s0   = (cnt_q == half - ONE_P);
  assign at_s1   = (cnt_q == half);
  assign at_vote = (cnt_q == half + ONE_P);
  assign at_end  = (cnt_q == p_q - ONE_P);

  // The third sample is the live line value at the vote point, so the
  // decision is available on the same edge the last sample is taken.
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);

  assign in_bit = (state_q == ST_START) || (state_q == ST_DATA) ||
                  (state_q == ST_PARITY) || (state_q == ST_STOP);

  always_comb begin
    sync_d     = {sync_q[0], S_Data};
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    zero_d     = zero_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    p_data_d   = p_data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    ovr_d      = 1'b0;
    brk_d      = 1'b0;

    // Registered handshake: an accepted word drops on the next edge unless
    // a new word overwrites it below.
    if (valid_q && Data_ready) begin
      valid_d = 1'b0;
    end

    if (in_bit) begin
      cnt_d = at_end ? '0 : cnt_q + ONE_P;
      if (at_s0) samp_d[0] = line;
      if (at_s1) samp_d[1] = line;
    end

    case (state_q)
      ST_IDLE: begin
        if (!line) begin
          state_d    = ST_START;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          p_d        = Prescale;
          par_en_d   = Parity_EN;
          par_type_d = Parity_type;
          stop2_d    = Stop_bits;
          stop_idx_d = 1'b0;
          zero_d     = 1'b1;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end

      ST_START: begin
        if (at_vote && vote) begin
          state_d = ST_IDLE;
        end else if (at_end) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
          zero_d  = zero_q & ~vote;
        end
        if (at_end) begin
          if (bit_cnt_q == DW_LAST) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (at_vote) begin
          // XOR over data and parity bit must equal the parity type
          par_err_d = (^shift_q) ^ vote ^ par_type_q;
          zero_d    = zero_q & ~vote;
        end
        if (at_end) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (at_vote) begin
          if (!vote) stop_err_d = 1'b1;
          if (!stop_idx_q && zero_q && !vote) begin
            brk_d   = 1'b1;
            state_d = ST_BREAK;
          end else if (stop_idx_q || !stop2_q) begin
            // Complete at mid-stop so a back-to-back start edge is not missed.
            state_d = ST_IDLE;
            if (!valid_q || Data_ready) begin
              p_data_d = shift_q;
              perr_d   = par_err_q;
              serr_d   = stop_err_q | ~vote;
              valid_d  = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
        if (at_end) begin
          stop_idx_d = 1'b1;
        end
      end

      ST_BREAK: begin
        if (line) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samp_q     <= 2'b11;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      zero_q     <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      zero_q     <= zero_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      ovr_q      <= ovr_d;
      brk_q      <= brk_d;
    end
  end

  assign P_Data        = p_data_q;
  assign Data_valid    = valid_q;
  assign Parity_error  = perr_q;
  assign stop_error    = serr_q;
  assign overrun_error = ovr_q;
  assign break_detect  = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8-bit instance (P=8) and a 5-bit
// instance (P=16), each fed from its own serial line.
module tb_uart_rx_param;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       s8, s5;
  logic       Parity_EN, Parity_type, Stop_bits, Data_ready;
  logic [5:0] Prescale;

  logic [7:0] pd8;
  logic       dv8, pe8, se8, ov8, bk8;
  logic [4:0] pd5;
  logic       dv5, pe5, se5, ov5, bk5;

  always #10 CLK = ~CLK;

  uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
    .CLK(CLK), .Reset(Reset), .S_Data(s8),
    .Parity_EN(Parity_EN), .Parity_type(Parity_type), .Stop_bits(Stop_bits),
    .Prescale(Prescale), .Data_ready(Data_ready),
    .P_Data(pd8), .Data_valid(dv8), .Parity_error(pe8), .stop_error(se8),
    .overrun_error(ov8), .break_detect(bk8)
  );

  uart_rx_param #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) dut5 (
    .CLK(CLK), .Reset(Reset), .S_Data(s5),
    .Parity_EN(Parity_EN), .Parity_type(Parity_type), .Stop_bits(Stop_bits),
    .Prescale(Prescale), .Data_ready(Data_ready),
    .P_Data(pd5), .Data_valid(dv5), .Parity_error(pe5), .stop_error(se5),
    .overrun_error(ov5), .break_detect(bk5)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // accepted-word log and pulse counters
  logic [8:0] w_data [0:63];
  logic       w_pe   [0:63];
  logic       w_se   [0:63];
  int w_cnt   = 0;
  int brk_cnt = 0;
  int ovr_cnt = 0;
  int rd      = 0;

  always @(negedge CLK) begin
    if (dv8 && Data_ready && w_cnt < 64) begin
      w_data[w_cnt] <= {1'b0, pd8};
      w_pe[w_cnt]   <= pe8;
      w_se[w_cnt]   <= se8;
      w_cnt         <= w_cnt + 1;
    end else if (dv5 && Data_ready && w_cnt < 64) begin
      w_data[w_cnt] <= {4'b0, pd5};
      w_pe[w_cnt]   <= pe5;
      w_se[w_cnt]   <= se5;
      w_cnt         <= w_cnt + 1;
    end
    brk_cnt <= brk_cnt + int'(bk8) + int'(bk5);
    ovr_cnt <= ovr_cnt + int'(ov8) + int'(ov5);
  end

  task automatic expect_word(input string tag, input logic [8:0] d, input logic pe, input logic se);
    if (rd < w_cnt) begin
      chk({tag, "_data"}, 32'(w_data[rd]), 32'(d));
      chk({tag, "_perr"}, 32'(w_pe[rd]), 32'(pe));
      chk({tag, "_serr"}, 32'(w_se[rd]), 32'(se));
      rd++;
    end else begin
      chk({tag, "_present"}, 32'(w_cnt), 32'(rd + 1));
    end
  endtask

  int p_cur = 8;

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input int sel, input logic b);
    if (sel == 0) s8 = b;
    else          s5 = b;
    idle(p_cur);
  endtask

  task automatic send(input int sel, input logic [8:0] d, input int nb, input logic pen,
                      input logic pb, input int nst, input logic st1, input logic st2);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
    if (pen) drive_bit(sel, pb);
    drive_bit(sel, st1);
    if (nst == 2) drive_bit(sel, st2);
    if (sel == 0) s8 = 1'b1;
    else          s5 = 1'b1;
  endtask

  int base_w, base_b, base_o;

  initial begin
    Reset       = 1'b0;
    s8          = 1'b1;
    s5          = 1'b1;
    Data_ready  = 1'b1;
    Prescale    = 6'd8;
    Parity_EN   = 1'b1;
    Parity_type = 1'b0;
    Stop_bits   = 1'b0;
    #35;
    chk("rst_pdata", 32'(pd8), 32'h0);
    chk("rst_valid", 32'(dv8), 32'h0);
    chk("rst_perr",  32'(pe8), 32'h0);
    chk("rst_serr",  32'(se8), 32'h0);
    chk("rst_ovr",   32'(ov8), 32'h0);
    chk("rst_brk",   32'(bk8), 32'h0);
    @(posedge CLK);
    #1 Reset = 1'b1;
    idle(4);

    // even parity, one stop bit, clean frames back to back
    base_w = w_cnt;
    send(0, 9'h0A, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    send(0, 9'h64, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    idle(16);
    chk("t1_nwords", 32'(w_cnt - base_w), 32'd2);
    expect_word("t1_w0", 9'h0A, 1'b0, 1'b0);
    expect_word("t1_w1", 9'h64, 1'b0, 1'b0);

    // parity error, then stop error
    base_w = w_cnt;
    send(0, 9'h0A, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    send(0, 9'h64, 8, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    idle(16);
    chk("t2_nwords", 32'(w_cnt - base_w), 32'd2);
    expect_word("t2_perr", 9'h0A, 1'b1, 1'b0);
    expect_word("t2_serr", 9'h64, 1'b0, 1'b1);

    // start glitch, then odd parity with two stop bits
    Parity_type = 1'b1;
    Stop_bits   = 1'b1;
    base_w = w_cnt;
    s8 = 1'b0;
    idle(1);
    s8 = 1'b1;
    idle(24);
    chk("t3_glitch_nwords", 32'(w_cnt - base_w), 32'd0);
    send(0, 9'h32, 8, 1'b1, 1'b0, 2, 1'b1, 1'b1);
    idle(16);
    expect_word("t3_odd2stop", 9'h32, 1'b0, 1'b0);
    send(0, 9'h32, 8, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    idle(16);
    expect_word("t3_stop2_low", 9'h32, 1'b0, 1'b1);

    // overrun with consumer stalled
    Parity_type = 1'b0;
    Stop_bits   = 1'b0;
    Data_ready  = 1'b0;
    base_w = w_cnt;
    base_o = ovr_cnt;
    send(0, 9'h11, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    send(0, 9'h22, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    idle(16);
    chk("t4_held_data", 32'(pd8), 32'h11);
    chk("t4_held_valid", 32'(dv8), 32'h1);
    chk("t4_ovr_pulses", 32'(ovr_cnt - base_o), 32'd1);
    chk("t4_nwords", 32'(w_cnt - base_w), 32'd0);
    Data_ready = 1'b1;
    chk("t4_valid_before_edge", 32'(dv8), 32'h1);
    idle(1);
    chk("t4_valid_after_edge", 32'(dv8), 32'h0);
    expect_word("t4_release", 9'h11, 1'b0, 1'b0);

    // break: line low for 15 bit times
    base_w = w_cnt;
    base_b = brk_cnt;
    s8 = 1'b0;
    idle(15 * 8);
    s8 = 1'b1;
    idle(16);
    chk("t5_brk_pulses", 32'(brk_cnt - base_b), 32'd1);
    chk("t5_nwords", 32'(w_cnt - base_w), 32'd0);
    send(0, 9'h55, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    idle(16);
    expect_word("t5_after_brk", 9'h55, 1'b0, 1'b0);

    // 5-bit instance, P=16, no parity
    Prescale  = 6'd16;
    p_cur     = 16;
    Parity_EN = 1'b0;
    base_w = w_cnt;
    send(1, 9'h16, 5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(32);
    expect_word("t6_dw5", 9'h16, 1'b0, 1'b0);

    // reset mid-frame
    s5 = 1'b0;
    idle(40);
    Reset = 1'b0;
    #1;
    chk("t6_rst_pd5",   32'(pd5), 32'h0);
    chk("t6_rst_dv5",   32'(dv5), 32'h0);
    chk("t6_rst_pd8",   32'(pd8), 32'h0);
    chk("t6_rst_flags", 32'({pe5, se5, ov5, bk5}), 32'h0);
    s5 = 1'b1;
    idle(3);
    Reset = 1'b1;
    idle(5);
    base_w = w_cnt;
    send(1, 9'h09, 5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(32);
    chk("t6_nwords", 32'(w_cnt - base_w), 32'd1);
    expect_word("t6_after_rst", 9'h09, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised second-generation UART receiver for the low-power communication system. It deserialises an asynchronous serial line into DATA_WIDTH-bit words using per-bit oversampling with 3-sample majority voting. Parity, stop-bit count and prescale are configurable at run time. Each word is delivered through a one-deep valid/ready output register with per-word error flags, overrun and break detection, and it feeds the system controller's RX path.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal 5..9.
- PRESCALE_WIDTH, 6: width of Prescale; oversampling ratio up to 2^PRESCALE_WIDTH-2.
- CLK  input  1  single system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- S_Data  input  1  serial line; idle high; asynchronous to CLK.
- Parity_EN  input  1  1 = parity bit present after the data bits.
- Parity_type  input  1  0 = even, 1 = odd.
- Stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- Prescale  input  PRESCALE_WIDTH  CLK cycles per bit; legal even values 6..2^PRESCALE_WIDTH-2.
- Data_ready  input  1  consumer accepts the word when Data_valid=1.
- P_Data  output  DATA_WIDTH  received word; LSB is the first bit received.
- Data_valid  output  1  P_Data and the flags hold a word.
- Parity_error  output  1  flag qualified by Data_valid: parity mismatch in the held word.
- stop_error  output  1  flag qualified by Data_valid: at least one stop sample was 0.
- overrun_error  output  1  one-cycle pulse when a completed frame is dropped.
- break_detect  output  1  one-cycle pulse when a break frame is recognised.

## Operation
- S_Data passes through a 2-flop synchroniser. "Line" below means the synchronised signal, which lags S_Data by 2 CLK.
- Edge counter cnt runs 0..P-1 within each bit. P is Prescale latched at start detection.
- Sample points are cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of these three samples.
- Parity_EN, Parity_type and Stop_bits are also latched at start detection. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when line=0, go to START with cnt=0. The bit counter is cleared.
- START: at cnt=P/2+1, if majority=1 the start is a glitch; go to IDLE with no output. Otherwise continue until cnt=P-1, then go to DATA.
- DATA: shift the voted bit in LSB-first. After bit DATA_WIDTH-1 completes, go to PARITY if Parity_EN=1, else STOP.
- PARITY: check the voted bit against the computed parity. Even parity requires the XOR of data and parity bit to be 0; odd parity requires 1.
- STOP: one or two stop bits are sampled. stop_error is set if any voted stop bit is 0.
- Frame completion happens at cnt=P/2+1 of the last stop bit; the FSM returns to IDLE on the same edge. The remaining half-bit is not waited out, so a back-to-back start is caught.
- Break frame: all data bits 0, parity bit 0 (if enabled) and first stop bit 0.
  - On a break frame, pulse break_detect, deliver nothing and go to BREAK.
  - BREAK waits for line=1, then goes to IDLE.
- Delivery on completion of a non-break frame:
  - If Data_valid=0, or Data_valid=1 and Data_ready=1 on that cycle, load P_Data, Parity_error and stop_error, and set Data_valid.
  - Otherwise drop the frame, keep the held word and pulse overrun_error.
- Frames containing errors are still delivered, with their flags set.
- Data_valid clears on the cycle after Data_valid=1 and Data_ready=1, unless a new word loads on that same edge.

## Timing
- Reset (asynchronous, active-low):
  - State IDLE; synchroniser flops are 1 (idle line).
  - P_Data=0, Data_valid=0, Parity_error=0, stop_error=0, overrun_error=0, break_detect=0.
  - Reset mid-frame discards the partial frame and any held word.
- Start detection: START is entered 3 CLK after S_Data falls (2 synchroniser cycles plus 1 state edge).
- Frame length in bit times: 1 + DATA_WIDTH + Parity_EN + (1 or 2).
- Data_valid rises on the edge that ends the cycle in which cnt=P/2+1 of the last stop bit.
  - Relative to the S_Data start falling edge, that is roughly (bits-1)*P + P/2 + 4 CLK.
- The handshake is registered: a word held with Data_ready=1 is removed 1 cycle after Data_valid rose.
- overrun_error and break_detect are high for exactly one CLK.
- The pulse-type outputs and the P_Data/flags update are fully registered; there are no combinational paths from inputs to outputs.

## Test plan
- Run the remaining scenarios with CLK=20 ns, P=8, DATA_WIDTH=8, Data_ready=1 except where stated.
- Parity_EN=1, even parity, one stop bit; send 0x0A with parity 0, then 0x64 with parity 1. Required: two words, 0x0A then 0x64, both with Parity_error=0 and stop_error=0.
- Send 0x0A with parity 1, then 0x64 with stop bit 0. Required: 0x0A with Parity_error=1; 0x64 with stop_error=1.
- Start glitch: S_Data low for 1 CLK, then high. Required: no Data_valid. Then send 0x32 with odd parity and Stop_bits=1, giving 0x32 delivered error-free. Repeat with the second stop bit 0: stop_error=1.
- Data_ready=0; send 0x11 then 0x22. Required: P_Data stays 0x11 and overrun_error pulses once. Set Data_ready=1: Data_valid falls 1 cycle later.
- Hold S_Data low for 15 bit times, then high. Required: one break_detect pulse, no Data_valid; a following 0x55 frame is received correctly.
- DATA_WIDTH=5, P=16, Parity_EN=0; send 5'b10110. Required: P_Data=5'b10110. Assert Reset mid-frame: all outputs 0 and the next frame is received cleanly.
